// File: rtl/sram_column_aligner.sv
// Rotates the SRAM read-out of a line buffer into a column ordered oldest-line-first and tracks x/y position.
// Optional build macro COLUMN_EDGE_REPLICATE_EN: masked rows copy the nearest enabled row toward the center.
module sram_column_aligner #(
  parameter int SRAM_SIZE    = 18,
  parameter int DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 12,
  parameter int IMAGE_WIDTH  = 4032,
  parameter int IMAGE_HEIGHT = 3024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SRAM_SIZE-1:0]                sram_rden_i,
  input  logic [4:0]                          head_num_i,
  input  logic [ADDR_WIDTH-1:0]               sram_addr_i,
  input  logic [SRAM_SIZE*DATA_WIDTH-1:0]     sram_rdata_i,
  output logic [(SRAM_SIZE-1)*DATA_WIDTH-1:0] col_data_o,
  output logic                                col_valid_o,
  output logic [ADDR_WIDTH-1:0]               col_x_o,
  output logic [15:0]                         col_y_o,
  output logic                                eol_o,
  output logic                                eof_o,
  output logic                                head_err_o
);

  localparam int ROWS   = SRAM_SIZE - 1;
  localparam int CENTER = (SRAM_SIZE - 2) / 2;
  localparam int COLW   = ROWS * DATA_WIDTH;

  logic [SRAM_SIZE-1:0]  rden_q;
  logic [4:0]            head_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [COLW-1:0]       data_q, col_d;
  logic [ADDR_WIDTH-1:0] x_q;
  logic [15:0]           y_q, y_d;
  logic                  valid_q, valid_d;
  logic                  eol_q, eol_d;
  logic                  eof_q, eof_d;
  logic                  err_q, head_bad_s;

  logic [DATA_WIDTH-1:0] raw_s  [ROWS];
  logic [DATA_WIDTH-1:0] fill_s [ROWS];
  logic [ROWS-1:0]       masked_s;
  int                    head_eff_s;
  int                    idx_s;

  // Align control/address with the one-cycle SRAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rden_q <= '0;
      head_q <= 5'd0;
      addr_q <= '0;
    end else begin
      rden_q <= sram_rden_i;
      head_q <= head_num_i;
      addr_q <= sram_addr_i;
    end
  end

  // Rotation and masking of the aligned read data.
  always_comb begin
    head_bad_s = (int'(head_q) >= SRAM_SIZE);
    head_eff_s = head_bad_s ? 0 : int'(head_q);
    idx_s      = 0;
    masked_s   = '0;
    col_d      = '0;
    for (int k = 0; k < ROWS; k++) begin
      raw_s[k]  = '0;
      fill_s[k] = '0;
    end
    for (int k = 0; k < ROWS; k++) begin
      idx_s = head_eff_s + k;
      if (idx_s >= SRAM_SIZE) begin
        idx_s = idx_s - SRAM_SIZE;
      end else begin
        idx_s = idx_s;
      end
      masked_s[k] = ~rden_q[idx_s];
      raw_s[k]    = masked_s[k] ? '0 : sram_rdata_i[idx_s*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef COLUMN_EDGE_REPLICATE_EN
    // Fill outward from the center so each masked row inherits its nearest inner neighbour.
    fill_s[CENTER] = raw_s[CENTER];
    for (int k = CENTER - 1; k >= 0; k--) begin
      fill_s[k] = masked_s[k] ? fill_s[k+1] : raw_s[k];
    end
    for (int k = CENTER + 1; k < ROWS; k++) begin
      fill_s[k] = masked_s[k] ? fill_s[k-1] : raw_s[k];
    end
    for (int k = 0; k < ROWS; k++) begin
      col_d[k*DATA_WIDTH +: DATA_WIDTH] = masked_s[CENTER] ? '0 : fill_s[k];
    end
`else
    for (int k = 0; k < ROWS; k++) begin
      fill_s[k] = raw_s[k];
      col_d[k*DATA_WIDTH +: DATA_WIDTH] = fill_s[k];
    end
`endif
  end

  // Line/frame position; y moves on the cycle after an end-of-line column.
  always_comb begin
    valid_d = |rden_q;
    eol_d   = valid_d && (addr_q == ADDR_WIDTH'(IMAGE_WIDTH - 1));
    if (eol_q) begin
      y_d = eof_q ? 16'd0 : (y_q + 16'd1);
    end else begin
      y_d = y_q;
    end
    eof_d = eol_d && (y_d == 16'(IMAGE_HEIGHT - 1));
  end

  // Output stage; column data and x only change on valid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      x_q     <= '0;
      y_q     <= 16'd0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      y_q     <= y_d;
      err_q   <= err_q | head_bad_s;
      if (valid_d) begin
        data_q <= col_d;
        x_q    <= addr_q;
      end else begin
        data_q <= data_q;
        x_q    <= x_q;
      end
    end
  end

  assign col_data_o  = data_q;
  assign col_valid_o = valid_q;
  assign col_x_o     = x_q;
  assign col_y_o     = y_q;
  assign eol_o       = eol_q;
  assign eof_o       = eof_q;
  assign head_err_o  = err_q;

endmodule

// File: tb/tb_sram_column_aligner.sv
// Scoreboard bench for sram_column_aligner: directed columns queued with expected values, checked by a monitor.
module tb_sram_column_aligner;

  localparam int N    = 18;
  localparam int DW   = 12;
  localparam int AW   = 12;
  localparam int ROWS = 17;
  localparam int COLW = ROWS * DW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      sram_rden_i = '0;
  logic [4:0]        head_num_i = 5'd0;
  logic [AW-1:0]     sram_addr_i = '0;
  logic [N*DW-1:0]   sram_rdata_i = '0;
  logic [COLW-1:0]   col_data_o;
  logic              col_valid_o;
  logic [AW-1:0]     col_x_o;
  logic [15:0]       col_y_o;
  logic              eol_o, eof_o, head_err_o;

  sram_column_aligner dut (
    .clk(clk), .rst(rst), .sram_rden_i(sram_rden_i), .head_num_i(head_num_i),
    .sram_addr_i(sram_addr_i), .sram_rdata_i(sram_rdata_i), .col_data_o(col_data_o),
    .col_valid_o(col_valid_o), .col_x_o(col_x_o), .col_y_o(col_y_o),
    .eol_o(eol_o), .eof_o(eof_o), .head_err_o(head_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COLW-1:0] data;
    logic [AW-1:0]   x;
    logic            eol;
    logic            eof;
    logic [15:0]     y;
    int              cyc;
  } exp_t;

  exp_t            sb[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              exp_y = 0;
  logic [N*DW-1:0] pend = '0;
  logic [COLW-1:0] last_data = '0;
  logic [AW-1:0]   last_x = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] srams(input int base);
    logic [N*DW-1:0] d;
    d = '0;
    for (int j = 0; j < N; j++) d[j*DW +: DW] = DW'(base + j);
    return d;
  endfunction

  function automatic logic [COLW-1:0] pack(input int v[ROWS]);
    logic [COLW-1:0] c;
    c = '0;
    for (int k = 0; k < ROWS; k++) c[k*DW +: DW] = DW'(v[k]);
    return c;
  endfunction

  // One clock of stimulus; read data of the previous address is presented alongside.
  task automatic step(input logic [N-1:0] rden, input logic [4:0] head, input logic [AW-1:0] addr,
                      input logic [N*DW-1:0] data, input logic [COLW-1:0] expcol);
    exp_t e;
    sram_rdata_i = pend;
    sram_rden_i  = rden;
    head_num_i   = head;
    sram_addr_i  = addr;
    pend         = data;
    if (rden != '0) begin
      e.data = expcol;
      e.x    = addr;
      e.eol  = (addr == AW'(4031));
      e.eof  = e.eol && (exp_y == 3023);
      e.y    = 16'(exp_y);
      e.cyc  = cyc + 2;
      sb.push_back(e);
      if (e.eol) exp_y = e.eof ? 0 : exp_y + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 5'd0, '0, '0, '0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_data"}, 256'(col_data_o), 256'd0);
    chk({nm, "_valid"}, 256'(col_valid_o), 256'd0);
    chk({nm, "_x"}, 256'(col_x_o), 256'd0);
    chk({nm, "_y"}, 256'(col_y_o), 256'd0);
    chk({nm, "_eol"}, 256'(eol_o), 256'd0);
    chk({nm, "_eof"}, 256'(eof_o), 256'd0);
    chk({nm, "_err"}, 256'(head_err_o), 256'd0);
  endtask

  // Monitor: pops one expectation per valid column and checks hold behaviour otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_data = '0;
      last_x = '0;
    end else if (col_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 256'(col_valid_o), 256'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("col_data", 256'(col_data_o), 256'(e.data));
        chk("col_x", 256'(col_x_o), 256'(e.x));
        chk("col_y", 256'(col_y_o), 256'(e.y));
        chk("eol", 256'(eol_o), 256'(e.eol));
        chk("eof", 256'(eof_o), 256'(e.eof));
        chk("latency", 256'(cyc), 256'(e.cyc));
      end
      last_data = col_data_o;
      last_x = col_x_o;
    end else begin
      chk("idle_eol", 256'(eol_o), 256'd0);
      chk("idle_eof", 256'(eof_o), 256'd0);
      chk("hold_data", 256'(col_data_o), 256'(last_data));
      chk("hold_x", 256'(col_x_o), 256'(last_x));
    end
  end

  initial begin
    int ev[ROWS];
    logic [COLW-1:0] c_ramp;

    #12;
    chk_all_zero("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    chk_all_zero("post_reset");

    // Head 0, SRAMs 0..16 enabled, SRAM j returns j.
    for (int k = 0; k < ROWS; k++) ev[k] = k;
    c_ramp = pack(ev);
    step(18'h1FFFF, 5'd0, 12'd10, srams(0), c_ramp);

    // Head 5, SRAM 4 off, SRAM j returns 100+j: rows 0,12,13,16 = 105,117,100,103.
    for (int k = 0; k < ROWS; k++) ev[k] = 100 + ((5 + k) % 18);
    step(18'h3FFEF, 5'd5, 12'd11, srams(100), pack(ev));

    // Head 0, only SRAMs 0..10 enabled.
    for (int k = 0; k < ROWS; k++) begin
`ifdef COLUMN_EDGE_REPLICATE_EN
      ev[k] = (k <= 10) ? k : 10;
`else
      ev[k] = (k <= 10) ? k : 0;
`endif
    end
    step(18'h007FF, 5'd0, 12'd12, srams(0), pack(ev));

    // Head 16 wraps; SRAM 1 off masks row 3 (below center).
    for (int k = 0; k < ROWS; k++) ev[k] = 200 + ((16 + k) % 18);
`ifdef COLUMN_EDGE_REPLICATE_EN
    ev[3] = 202;
`else
    ev[3] = 0;
`endif
    step(18'h3FFFD, 5'd16, 12'd13, srams(200), pack(ev));
    idle(4);

    // Full line sweep: eol at x=4031 and y steps afterwards.
    for (int a = 0; a < 4032; a++) step(18'h1FFFF, 5'd0, AW'(a), srams(0), c_ramp);
    idle(3);
    chk("y_after_line", 256'(col_y_o), 256'd1);

    // Remaining 3023 lines as single end-of-line columns; last one is end of frame.
    for (int l = 1; l < 3024; l++) step(18'h1FFFF, 5'd0, 12'd4031, srams(0), c_ramp);
    idle(3);
    chk("y_after_frame", 256'(col_y_o), 256'd0);

    step(18'h1FFFF, 5'd0, 12'd4031, srams(0), c_ramp);
    step(18'h1FFFF, 5'd0, 12'd5, srams(0), c_ramp);
    idle(3);
    chk("y_before_reset", 256'(col_y_o), 256'd1);

    // Out-of-range head forces rotation to 0 and sets the sticky error.
    for (int k = 0; k < ROWS; k++) ev[k] = k;
    step(18'h3FFFF, 5'd20, 12'd6, srams(0), pack(ev));
    idle(3);
    chk("head_err_set", 256'(head_err_o), 256'd1);
    idle(3);
    chk("head_err_sticky", 256'(head_err_o), 256'd1);

    // Mid-line reset with columns in flight.
    step(18'h1FFFF, 5'd0, 12'd7, srams(0), c_ramp);
    step(18'h1FFFF, 5'd0, 12'd8, srams(0), c_ramp);
    rst = 1'b1;
    sb.delete();
    exp_y = 0;
    pend = '0;
    #2;
    chk_all_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    chk_all_zero("after_mid_reset");

    step(18'h1FFFF, 5'd0, 12'd3, srams(0), c_ramp);
    idle(4);
    chk("scoreboard_drained", 256'(sb.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
